// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the ingress packet router
package router_pkg;

   localparam int DATA_W    = 8;
   localparam int NUM_PORTS = 4;
   localparam int PORT_W    = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      IDLE = 2'd1,
      FWD  = 2'd2,
      DROP = 2'd3
   } state_t;

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/router_sync_fifo.sv
// rtl/router_sync_fifo.sv - single-clock FIFO with count/full/empty, generic entry type
module router_sync_fifo
   import router_pkg::*;
#(
   parameter int  DEPTH   = 16,
   parameter type entry_t = fifo_entry_t
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     push,
   input  entry_t                   push_entry,
   input  logic                     pop,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // a push into a full FIFO is only taken when a pop frees the slot in the same cycle
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[AW-1:0]];

   // pointers carry one extra MSB so full and empty are distinguishable
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage array needs no reset; the read side is qualified by empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/ingress_pkt_router.sv
// rtl/ingress_pkt_router.sv - address-match ingress router with byte FIFO; ROUTER_STATS_EN adds pkt_cnt/drop_cnt
module ingress_pkt_router
   import router_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = router_pkg::DATA_W
`ifdef ROUTER_STATS_EN
   ,parameter int CNT_W     = 16
`endif
) (
   input  logic              fast_clk,
   input  logic              reset_b,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data,
   output logic              data_stall,
   input  logic [DATA_W-1:0] addr_port_0,
   input  logic [DATA_W-1:0] addr_port_1,
   input  logic [DATA_W-1:0] addr_port_2,
   input  logic [DATA_W-1:0] addr_port_3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic [1:0]        out_port
`ifdef ROUTER_STATS_EN
   ,output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0]  drop_cnt
`endif
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] STALL_TH = (AW+1)'(FIFO_DEPTH - 2);

   state_t            state;
   logic [DATA_W-1:0] hold_data;
   logic              hold_sop;
   logic [1:0]        port_q;
   logic              eop_pending;

   logic              accept;
   logic              hit;
   logic [1:0]        hit_idx;
   logic              push;
   logic              push_fire;
   logic              pop;
   logic              eop_phase;
   logic              eop_pending_next;
   fifo_entry_t       push_entry;
   fifo_entry_t       head;
   logic [AW:0]       fifo_count;
   logic [AW:0]       count_next;
   logic              fifo_full;
   logic              fifo_empty;

   assign accept    = data_valid && !data_stall;
   assign pop       = out_valid && out_ready;
   assign push_fire = push && (!fifo_full || pop);
   assign eop_phase = (state == FWD) && (eop_pending || !data_valid);

   // address match with port 0 taking priority over 1, 2, 3
   always_comb begin
      hit     = 1'b1;
      hit_idx = 2'd0;
      if      (data == addr_port_0) hit_idx = 2'd0;
      else if (data == addr_port_1) hit_idx = 2'd1;
      else if (data == addr_port_2) hit_idx = 2'd2;
      else if (data == addr_port_3) hit_idx = 2'd3;
      else                          hit     = 1'b0;
   end

   // the held byte goes to the FIFO when its successor arrives, or with eop when the packet ends
   always_comb begin
      push       = 1'b0;
      push_entry = '{port: port_q, sop: hold_sop, eop: 1'b0, data: hold_data};
      if (eop_phase) begin
         push           = 1'b1;
         push_entry.eop = 1'b1;
      end else if (state == FWD && accept) begin
         push = 1'b1;
      end
   end

   assign count_next       = fifo_count + (AW+1)'(push_fire) - (AW+1)'(pop);
   assign eop_pending_next = eop_phase && !push_fire;

   // packet framing state machine with registered stall
   always_ff @(posedge fast_clk or negedge reset_b) begin
      if (!reset_b) begin
         state       <= SYNC;
         hold_data   <= '0;
         hold_sop    <= 1'b0;
         port_q      <= 2'd0;
         eop_pending <= 1'b0;
         data_stall  <= 1'b0;
      end else begin
         data_stall  <= (count_next >= STALL_TH) || eop_pending_next;
         eop_pending <= eop_pending_next;
         case (state)
            SYNC: if (!data_valid) state <= IDLE;
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     port_q    <= hit_idx;
                     hold_data <= data;
                     hold_sop  <= 1'b1;
                     state     <= FWD;
                  end else begin
                     state <= DROP;
                  end
               end
            end
            FWD: begin
               if (eop_phase) begin
                  if (push_fire) state <= IDLE;
               end else if (accept) begin
                  hold_data <= data;
                  hold_sop  <= 1'b0;
               end
            end
            DROP: if (!data_valid) state <= IDLE;
            default: state <= SYNC;
         endcase
      end
   end

   router_sync_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fifo_entry_t)
   ) u_fifo (
      .clk        (fast_clk),
      .reset_b    (reset_b),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0    : head.data;
   assign out_sop   = fifo_empty ? 1'b0  : head.sop;
   assign out_eop   = fifo_empty ? 1'b0  : head.eop;
   assign out_port  = fifo_empty ? 2'd0  : head.port;

`ifdef ROUTER_STATS_EN
   // saturating counters: forwarded packets on eop push, dropped packets on entry to DROP
   always_ff @(posedge fast_clk or negedge reset_b) begin
      if (!reset_b) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (eop_phase && push_fire && pkt_cnt != '1)
            pkt_cnt <= pkt_cnt + 1'b1;
         if (state == IDLE && accept && !hit && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

endmodule
